// File: rtl/jtpinpon_romarb.sv
`default_nettype none
// ============================================================================
//  Module      : jtpinpon_romarb
//  Description : Shares one SDRAM read slot between the scroll (char) and
//                object ROM fetchers of the Pin Pon video. Each client sees
//                a ROM-like cs/addr/data/ok port backed by a one-entry cache
//                of the last word fetched. Misses are serialised onto the
//                SDRAM req/ack/dst handshake with round-robin priority.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                scr_cs/scr_addr/scr_data/scr_ok - scroll ROM client port
//                obj_cs/obj_addr/obj_data/obj_ok - object ROM client port
//                sdr_addr/sdr_req              - SDRAM read request (registered)
//                sdr_ack/sdr_dst/sdr_data      - SDRAM accept / data strobe / data
//  Revision    : 1.0 - initial release
// ============================================================================
module jtpinpon_romarb #(
    parameter int          SCR_AW     = 13,
    parameter int          OBJ_AW     = 13,
    parameter logic [21:0] SCR_OFFSET = 22'h0,
    parameter logic [21:0] OBJ_OFFSET = 22'h2000,
    parameter int          TIMEOUT    = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scr_cs,
    input  logic [SCR_AW-1:0] scr_addr,
    output logic [31:0]       scr_data,
    output logic              scr_ok,
    input  logic              obj_cs,
    input  logic [OBJ_AW-1:0] obj_addr,
    output logic [31:0]       obj_data,
    output logic              obj_ok,
    output logic [21:0]       sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_ack,
    input  logic              sdr_dst,
    input  logic [31:0]       sdr_data
);

    localparam int         c_tagw    = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;
    localparam logic [5:0] c_timeout = 6'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_rr;        // 0: scroll granted last on contention, 1: object
    logic              r_owner;     // 0: scroll, 1: object
    logic [c_tagw-1:0] r_ptag;      // address issued for the transaction in flight
    logic [5:0]        r_cnt;
    logic              r_sdr_req;
    logic [21:0]       r_sdr_addr;

    logic              r_scr_valid;
    logic [SCR_AW-1:0] r_scr_tag;
    logic [31:0]       r_scr_data;
    logic              r_obj_valid;
    logic [OBJ_AW-1:0] r_obj_tag;
    logic [31:0]       r_obj_data;

    logic w_scr_hit, w_obj_hit;
    logic w_scr_pend, w_obj_pend;
    logic w_busy;
    logic w_gnt_obj;
    logic w_fill;
    logic [5:0] w_cnt_nxt;

    // Hits are purely combinational so a cached word costs no extra latency.
    assign w_scr_hit = scr_cs & r_scr_valid & (scr_addr == r_scr_tag);
    assign w_obj_hit = obj_cs & r_obj_valid & (obj_addr == r_obj_tag);

    // The client whose fetch is already in flight must not queue a duplicate.
    assign w_busy     = (r_state != ST_IDLE);
    assign w_scr_pend = scr_cs & ~w_scr_hit & ~(w_busy & ~r_owner);
    assign w_obj_pend = obj_cs & ~w_obj_hit & ~(w_busy &  r_owner);

    // Sole requester wins; on contention the client not named by r_rr wins.
    assign w_gnt_obj = w_obj_pend & (~w_scr_pend | ~r_rr);

    // Data accepted in WAIT, or in REQ when it coincides with the ack.
    assign w_fill = sdr_dst & ((r_state == ST_WAIT) | ((r_state == ST_REQ) & sdr_ack));

    assign w_cnt_nxt = r_cnt + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= 1'b0;
            r_owner     <= 1'b0;
            r_ptag      <= '0;
            r_cnt       <= 6'd0;
            r_sdr_req   <= 1'b0;
            r_sdr_addr  <= 22'd0;
            r_scr_valid <= 1'b0;
            r_scr_tag   <= '0;
            r_scr_data  <= 32'd0;
            r_obj_valid <= 1'b0;
            r_obj_tag   <= '0;
            r_obj_data  <= 32'd0;
        end else begin
            if (w_fill) begin
                if (r_owner) begin
                    r_obj_valid <= 1'b1;
                    r_obj_tag   <= r_ptag[OBJ_AW-1:0];
                    r_obj_data  <= sdr_data;
                end else begin
                    r_scr_valid <= 1'b1;
                    r_scr_tag   <= r_ptag[SCR_AW-1:0];
                    r_scr_data  <= sdr_data;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_scr_pend | w_obj_pend) begin
                        if (w_scr_pend & w_obj_pend) begin
                            r_rr <= w_gnt_obj;
                        end
                        r_owner <= w_gnt_obj;
                        if (w_gnt_obj) begin
                            r_ptag     <= c_tagw'(obj_addr);
                            r_sdr_addr <= OBJ_OFFSET + 22'(obj_addr);
                        end else begin
                            r_ptag     <= c_tagw'(scr_addr);
                            r_sdr_addr <= SCR_OFFSET + 22'(scr_addr);
                        end
                        r_sdr_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdr_ack) begin
                        r_sdr_req <= 1'b0;
                        r_cnt     <= 6'd0;
                        r_state   <= sdr_dst ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sdr_dst) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Abandon the fetch after TIMEOUT silent cycles; the
                        // cache is left untouched and the miss re-arbitrates.
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == c_timeout) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_sdr_req <= 1'b0;
                end
            endcase
        end
    end

    assign scr_ok   = w_scr_hit;
    assign obj_ok   = w_obj_hit;
    assign scr_data = r_scr_data;
    assign obj_data = r_obj_data;
    assign sdr_req  = r_sdr_req;
    assign sdr_addr = r_sdr_addr;

endmodule
`default_nettype wire

// File: tb/tb_jtpinpon_romarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtpinpon_romarb
//  Description : Directed self-checking bench for jtpinpon_romarb. A
//                transaction-level cache model (per-client valid/tag/data,
//                updated when the bench delivers data for an expected grant)
//                is compared against the client ports on every negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtpinpon_romarb;

    logic        clk = 1'b0;
    logic        rst;
    logic        scr_cs, obj_cs;
    logic [12:0] scr_addr, obj_addr;
    logic [31:0] scr_data, obj_data;
    logic        scr_ok, obj_ok;
    logic [21:0] sdr_addr;
    logic        sdr_req, sdr_ack, sdr_dst;
    logic [31:0] sdr_data;

    always #5 clk = ~clk;

    jtpinpon_romarb dut (
        .clk      (clk),
        .rst      (rst),
        .scr_cs   (scr_cs),
        .scr_addr (scr_addr),
        .scr_data (scr_data),
        .scr_ok   (scr_ok),
        .obj_cs   (obj_cs),
        .obj_addr (obj_addr),
        .obj_data (obj_data),
        .obj_ok   (obj_ok),
        .sdr_addr (sdr_addr),
        .sdr_req  (sdr_req),
        .sdr_ack  (sdr_ack),
        .sdr_dst  (sdr_dst),
        .sdr_data (sdr_data)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    // Client cache model: index 0 = scroll, 1 = object.
    logic        m_valid [2];
    logic [12:0] m_tag   [2];
    logic [31:0] m_data  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 13'd0;
            m_data[i]  = 32'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ok must equal "requested, and the model holds that address"; data is the cached word.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("mon_scr_ok",   {31'd0, scr_ok}, {31'd0, scr_cs && m_valid[0] && (m_tag[0] == scr_addr)});
            check("mon_obj_ok",   {31'd0, obj_ok}, {31'd0, obj_cs && m_valid[1] && (m_tag[1] == obj_addr)});
            check("mon_scr_data", scr_data, m_data[0]);
            check("mon_obj_data", obj_data, m_data[1]);
        end
    end

    task automatic wait_req(input logic [21:0] exp_addr, input string name);
        int n = 0;
        while (!sdr_req && n < 100) begin
            tick();
            n++;
        end
        check({name, "_req"},  {31'd0, sdr_req}, 32'd1);
        check({name, "_addr"}, {10'd0, sdr_addr}, {10'd0, exp_addr});
    endtask

    task automatic do_ack();
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
    endtask

    task automatic do_dst(input int owner, input logic [12:0] tag, input logic [31:0] data);
        sdr_dst  = 1'b1;
        sdr_data = data;
        tick();
        sdr_dst        = 1'b0;
        m_valid[owner] = 1'b1;
        m_tag[owner]   = tag;
        m_data[owner]  = data;
    endtask

    task automatic serve(input int owner, input logic [12:0] tag, input logic [31:0] data, input int gap);
        do_ack();
        repeat (gap - 1) tick();
        do_dst(owner, tag, data);
    endtask

    // Ack and data strobe land on the same cycle.
    task automatic serve_same(input int owner, input logic [12:0] tag, input logic [31:0] data);
        sdr_ack = 1'b1;
        do_dst(owner, tag, data);
        sdr_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; scr_cs = 1'b0; obj_cs = 1'b0; scr_addr = 13'd0; obj_addr = 13'd0;
        sdr_ack = 1'b0; sdr_dst = 1'b0; sdr_data = 32'd0;
        model_clear();

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_req",      {31'd0, sdr_req}, 32'd0);
        check("rst_scr_ok",   {31'd0, scr_ok},  32'd0);
        check("rst_obj_ok",   {31'd0, obj_ok},  32'd0);
        check("rst_scr_data", scr_data, 32'd0);
        check("rst_obj_data", obj_data, 32'd0);
        mon_en = 1'b1;

        // Basic miss then hit
        scr_cs = 1'b1; scr_addr = 13'h0012;
        tick();
        wait_req(22'h000012, "miss1");
        serve(0, 13'h0012, 32'hDEADBEEF, 3);
        check("miss1_ok",   {31'd0, scr_ok}, 32'd1);
        check("miss1_data", scr_data, 32'hDEADBEEF);
        scr_cs = 1'b0;
        tick();
        scr_cs = 1'b1;
        #1;
        check("hit_ok",  {31'd0, scr_ok},  32'd1);
        check("hit_req", {31'd0, sdr_req}, 32'd0);
        tick();
        check("hit_req2", {31'd0, sdr_req}, 32'd0);

        // Round-robin from reset: both clients keep missing at every arbitration
        scr_cs = 1'b0; obj_cs = 1'b0;
        rst = 1'b1;
        tick(); tick();
        model_clear();
        rst = 1'b0;
        scr_cs = 1'b1; scr_addr = 13'h0020;
        obj_cs = 1'b1; obj_addr = 13'h0005;
        tick();
        wait_req(22'h002005, "rr1");
        obj_addr = 13'h0006;
        serve(1, 13'h0005, 32'h11111111, 2);
        check("rr1_obj_ok", {31'd0, obj_ok}, 32'd0);
        wait_req(22'h000020, "rr2");
        scr_addr = 13'h0021;
        serve(0, 13'h0020, 32'h22222222, 1);
        wait_req(22'h002006, "rr3");
        serve_same(1, 13'h0006, 32'h33333333);
        check("rr3_obj_ok",   {31'd0, obj_ok}, 32'd1);
        check("rr3_obj_data", obj_data, 32'h33333333);
        wait_req(22'h000021, "rr4");
        serve(0, 13'h0021, 32'h44444444, 4);
        check("rr4_scr_ok", {31'd0, scr_ok}, 32'd1);

        // Address change while in flight
        scr_addr = 13'h0012;
        tick();
        wait_req(22'h000012, "chg1");
        do_ack();
        tick();
        scr_addr = 13'h0013;
        tick();
        do_dst(0, 13'h0012, 32'h55555555);
        check("chg1_ok", {31'd0, scr_ok}, 32'd0);
        wait_req(22'h000013, "chg2");
        serve(0, 13'h0013, 32'h66666666, 2);
        check("chg2_ok",   {31'd0, scr_ok}, 32'd1);
        check("chg2_data", scr_data, 32'h66666666);

        // Timeout, with a stray strobe before the ack
        obj_addr = 13'h0100;
        tick();
        wait_req(22'h002100, "tmo1");
        sdr_dst = 1'b1; sdr_data = 32'hBAD0BAD0;
        tick();
        sdr_dst = 1'b0;
        check("tmo_stray", obj_data, 32'h33333333);
        do_ack();
        n = 0;
        while (!sdr_req && n < 100) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 32'd64);
        check("tmo_addr", {10'd0, sdr_addr}, {10'd0, 22'h002100});
        check("tmo_ok", {31'd0, obj_ok}, 32'd0);
        serve(1, 13'h0100, 32'h77777777, 3);
        check("tmo_fill_ok", {31'd0, obj_ok}, 32'd1);

        // Reset during WAIT, late strobe ignored
        obj_cs = 1'b0;
        scr_addr = 13'h0040;
        tick();
        wait_req(22'h000040, "rw1");
        do_ack();
        tick();
        rst = 1'b1;
        tick();
        model_clear();
        rst = 1'b0;
        sdr_dst = 1'b1; sdr_data = 32'h88888888;
        tick();
        sdr_dst = 1'b0;
        check("rw_ok",   {31'd0, scr_ok}, 32'd0);
        check("rw_data", scr_data, 32'd0);
        wait_req(22'h000040, "rw2");
        serve(0, 13'h0040, 32'h99999999, 2);
        check("rw_fill_ok", {31'd0, scr_ok}, 32'd1);

        scr_cs = 1'b0;
        tick(); tick();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
